// File: rtl/mips_mc.sv
// mips_mc -- multi-cycle MIPS-lite core (nop, addu, subu, ori, lui, lw, sw,
// beq, jal, jr) built around one shared datapath.
// The datapath has a 32-entry GRF, IR/A/B/ALUOut/MDR holding registers and
// an FSM sequencer. One unified instruction/data memory sits behind a
// req/ack port.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high
//   mem_req    out  access request, held until mem_ack
//   mem_we     out  1 = write (sw), 0 = read
//   mem_addr   out  word-aligned byte address
//   mem_wdata  out  store data, valid while mem_req & mem_we
//   mem_rdata  in   read data, valid in the mem_ack cycle
//   mem_ack    in   access completes this cycle (may rise with mem_req)
//   retire     out  one-cycle pulse when an instruction completes
//   retire_pc  out  PC of the retiring instruction (0 when retire is low)
//   halted     out  core stopped after an undecodable instruction
//
// Memory handshake: a transfer happens in every cycle where mem_req and
// mem_ack are both high. While mem_req is high and mem_ack is low, mem_we,
// mem_addr and mem_wdata stay stable. mem_req is only dropped without an
// ack when reset is asserted, so the memory must tolerate an abandoned
// request.
module mips_mc #(
  parameter logic [31:0] PC_INIT         = 32'h0000_3000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        retire,
  output logic [31:0] retire_pc,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADDU, OP_SUBU, OP_JR, OP_ORI, OP_LUI,
    OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_ILL
  } op_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] grf_q [32];

  logic        grf_we;
  logic [4:0]  grf_waddr;
  logic [31:0] grf_wdata;

  logic        req_c, we_c, retire_c;
  logic [31:0] addr_c, wdata_c;

  // Instruction fields, always taken from the latched IR.
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] index;
  op_e         op;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign imm    = ir_q[15:0];
  assign index  = ir_q[25:0];

  always_comb begin
    op = OP_ILL;
    if (ir_q == 32'h0) begin
      op = OP_NOP;
    end else begin
      case (opcode)
        6'h00: begin
          case (funct)
            6'h21:   op = OP_ADDU;
            6'h23:   op = OP_SUBU;
            6'h08:   op = OP_JR;
            default: op = OP_ILL;
          endcase
        end
        6'h0D:   op = OP_ORI;
        6'h0F:   op = OP_LUI;
        6'h23:   op = OP_LW;
        6'h2B:   op = OP_SW;
        6'h04:   op = OP_BEQ;
        6'h03:   op = OP_JAL;
        default: op = OP_ILL;
      endcase
    end
  end

  // $0 never holds a value, so reads of it are forced to zero.
  logic [31:0] rs_val, rt_val, pc_plus4, imm_sext, br_target;

  assign rs_val    = (rs == 5'd0) ? 32'h0 : grf_q[rs];
  assign rt_val    = (rt == 5'd0) ? 32'h0 : grf_q[rt];
  assign pc_plus4  = pc_q + 32'd4;
  assign imm_sext  = {{16{imm[15]}}, imm};
  assign br_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    grf_we    = 1'b0;
    grf_waddr = 5'd0;
    grf_wdata = 32'h0;
    req_c     = 1'b0;
    we_c      = 1'b0;
    addr_c    = 32'h0;
    wdata_c   = 32'h0;
    retire_c  = 1'b0;

    case (state_q)
      S_FETCH: begin
        req_c  = 1'b1;
        addr_c = pc_q;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        a_d = rs_val;
        b_d = rt_val;
        if (op == OP_NOP || (op == OP_ILL && !HALT_ON_ILLEGAL)) begin
          pc_d     = pc_plus4;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (op == OP_ILL) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (op)
          OP_ADDU: begin alu_d = a_q + b_q;             state_d = S_WB; end
          OP_SUBU: begin alu_d = a_q - b_q;             state_d = S_WB; end
          OP_ORI:  begin alu_d = a_q | {16'h0, imm};    state_d = S_WB; end
          OP_LUI:  begin alu_d = {imm, 16'h0};          state_d = S_WB; end
          OP_LW, OP_SW: begin
            // Effective address is silently word-aligned.
            alu_d   = (a_q + imm_sext) & 32'hFFFF_FFFC;
            state_d = S_MEM;
          end
          OP_BEQ: begin
            pc_d     = (a_q == b_q) ? br_target : pc_plus4;
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
          OP_JAL: begin
            grf_we    = 1'b1;
            grf_waddr = 5'd31;
            grf_wdata = pc_plus4;
            pc_d      = {pc_plus4[31:28], index, 2'b00};
            retire_c  = 1'b1;
            state_d   = S_FETCH;
          end
          OP_JR: begin
            pc_d     = a_q;
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        req_c   = 1'b1;
        addr_c  = alu_q;
        we_c    = (op == OP_SW);
        wdata_c = (op == OP_SW) ? b_q : 32'h0;
        if (mem_ack) begin
          if (op == OP_SW) begin
            pc_d     = pc_plus4;
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        grf_we    = 1'b1;
        grf_waddr = (op == OP_ADDU || op == OP_SUBU) ? rd : rt;
        grf_wdata = (op == OP_LW) ? mdr_q : alu_q;
        pc_d      = pc_plus4;
        retire_c  = 1'b1;
        state_d   = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= PC_INIT;
      ir_q    <= 32'h0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      alu_q   <= 32'h0;
      mdr_q   <= 32'h0;
      for (int i = 0; i < 32; i++) grf_q[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      if (grf_we && grf_waddr != 5'd0) grf_q[grf_waddr] <= grf_wdata;
    end
  end

  // The state register resets to FETCH, which would otherwise request a
  // fetch while reset is still high; every output is forced quiet instead.
  assign mem_req   = req_c & ~reset;
  assign mem_we    = we_c & ~reset;
  assign mem_addr  = reset ? 32'h0 : addr_c;
  assign mem_wdata = reset ? 32'h0 : wdata_c;
  assign retire    = retire_c & ~reset;
  assign retire_pc = (retire_c && !reset) ? pc_q : 32'h0;
  assign halted    = (state_q == S_HALT) && !reset;

endmodule

// File: tb/tb_mips_mc.sv
// Testbench for mips_mc: a unified memory model with a slow data region,
// a table-driven straight-line program, and hand sequences for wait
// states, branches/jumps, halting and reset during a pending store.
module tb_mips_mc;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (halts on illegal) ----------------
  logic        mem_req, mem_we, mem_ack, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, retire_pc;

  mips_mc #(.PC_INIT(32'h0000_3000), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .retire(retire), .retire_pc(retire_pc), .halted(halted)
  );

  // ---------------- second DUT (illegal retires as nop) ----------------
  logic        mem_req2, mem_we2, mem_ack2, retire2, halted2;
  logic [31:0] mem_addr2, mem_wdata2, mem_rdata2, retire_pc2;

  mips_mc #(.PC_INIT(32'h0000_3000), .HALT_ON_ILLEGAL(1'b0)) dut_nohalt (
    .clk(clk), .reset(reset),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .mem_ack(mem_ack2),
    .retire(retire2), .retire_pc(retire_pc2), .halted(halted2)
  );

  assign mem_ack2   = mem_req2;
  assign mem_rdata2 = (mem_addr2 == 32'h0000_3000) ? 32'hFC00_0000 : 32'h0;

  // ---------------- memory model ----------------
  // Code region (>= 0x3000) answers with zero wait; data region below it
  // inserts data_wait wait states per access.
  logic [31:0] imem [4096];
  logic [31:0] dmem [4096];
  int          data_wait;
  int          wait_cnt;
  int          n_writes;
  logic        slow;

  assign slow      = (mem_addr < 32'h0000_3000);
  assign mem_ack   = mem_req && ((slow ? data_wait : 0) == wait_cnt);
  assign mem_rdata = slow ? dmem[mem_addr[13:2]] : imem[mem_addr[13:2]];

  initial begin
    wait_cnt = 0;
    n_writes = 0;
  end

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
    if (mem_req && mem_ack && mem_we) begin
      dmem[mem_addr[13:2]] <= mem_wdata;
      n_writes <= n_writes + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_cmp;
  int          n_fail;
  logic [31:0] exp_q[$];
  logic        r_we;
  logic [31:0] r_addr, r_wdata, r_pc;
  int          cyc;

  task automatic check32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_imem();
    for (int i = 0; i < 4096; i++) imem[i] = 32'h0;
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] instr);
    imem[addr[13:2]] = instr;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Waits for the next retire pulse, checks retire_pc and captures the
  // memory-port state of that cycle; cycles counts negedges waited.
  task automatic wait_retire(input string name, input logic [31:0] exp_pc,
                             output int cycles);
    bit got;
    got    = 1'b0;
    cycles = 0;
    while (!got && cycles < 60) begin
      @(negedge clk);
      cycles++;
      if (retire === 1'b1) begin
        got     = 1'b1;
        r_pc    = retire_pc;
        r_we    = mem_we;
        r_addr  = mem_addr;
        r_wdata = mem_wdata;
      end
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: no retire within 60 cycles, expected pc 0x%08h",
               name, exp_pc);
    end else begin
      check32(name, r_pc, exp_pc);
    end
  endtask

  task automatic check_store(input string name, input logic [31:0] exp_addr,
                             input logic [31:0] exp_data);
    check1({name, "_we"}, r_we, 1'b1);
    check32({name, "_addr"}, r_addr, exp_addr);
    check32({name, "_data"}, r_wdata, exp_data);
  endtask

  task automatic check_fetch(input string name, input logic [31:0] exp_addr);
    @(negedge clk);
    check1({name, "_req"}, mem_req, 1'b1);
    check32({name, "_addr"}, mem_addr, exp_addr);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] instr;
    logic        st;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [18];

  // ---------------- test ----------------
  initial begin
    int quiet;
    int saved_writes;
    n_cmp     = 0;
    n_fail    = 0;
    reset     = 1'b1;
    data_wait = 0;
    clear_imem();

    // Straight-line program at 0x3000; every instruction retires in order.
    vecs[0]  = '{32'h3401_1234, 1'b0, 32'h0,   32'h0};          // ori  $1,$0,0x1234
    vecs[1]  = '{32'h3C02_ABCD, 1'b0, 32'h0,   32'h0};          // lui  $2,0xABCD
    vecs[2]  = '{32'h0022_1821, 1'b0, 32'h0,   32'h0};          // addu $3,$1,$2
    vecs[3]  = '{32'h0001_2023, 1'b0, 32'h0,   32'h0};          // subu $4,$0,$1
    vecs[4]  = '{32'h0021_0021, 1'b0, 32'h0,   32'h0};          // addu $0,$1,$1
    vecs[5]  = '{32'h0000_0000, 1'b0, 32'h0,   32'h0};          // nop
    vecs[6]  = '{32'hAC01_0100, 1'b1, 32'h100, 32'h0000_1234};  // sw $1,0x100($0)
    vecs[7]  = '{32'hAC02_0104, 1'b1, 32'h104, 32'hABCD_0000};  // sw $2,0x104($0)
    vecs[8]  = '{32'hAC03_0108, 1'b1, 32'h108, 32'hABCD_1234};  // sw $3
    vecs[9]  = '{32'hAC04_010C, 1'b1, 32'h10C, 32'hFFFF_EDCC};  // sw $4
    vecs[10] = '{32'hAC00_0110, 1'b1, 32'h110, 32'h0000_0000};  // sw $0
    vecs[11] = '{32'h3406_0200, 1'b0, 32'h0,   32'h0};          // ori  $6,$0,0x200
    vecs[12] = '{32'hACC1_FFFC, 1'b1, 32'h1FC, 32'h0000_1234};  // sw $1,-4($6)
    vecs[13] = '{32'hACC2_0003, 1'b1, 32'h200, 32'hABCD_0000};  // sw $2,3($6)
    vecs[14] = '{32'h8C05_0100, 1'b0, 32'h0,   32'h0};          // lw $5,0x100($0)
    vecs[15] = '{32'hAC05_0114, 1'b1, 32'h114, 32'h0000_1234};  // sw $5
    vecs[16] = '{32'h3487_00FF, 1'b0, 32'h0,   32'h0};          // ori  $7,$4,0xFF
    vecs[17] = '{32'hAC07_0118, 1'b1, 32'h118, 32'hFFFF_EDFF};  // sw $7

    // ---- reset state, table program, nohalt illegal ----
    for (int i = 0; i < 18; i++) put(32'h3000 + 32'(4 * i), vecs[i].instr);
    hold_reset();
    check1("rst_req", mem_req, 1'b0);
    check1("rst_we", mem_we, 1'b0);
    check32("rst_addr", mem_addr, 32'h0);
    check32("rst_wdata", mem_wdata, 32'h0);
    check1("rst_retire", retire, 1'b0);
    check32("rst_retire_pc", retire_pc, 32'h0);
    check1("rst_halted", halted, 1'b0);
    check1("rst_req2", mem_req2, 1'b0);
    reset = 1'b0;
    #1;
    check1("first_fetch_req", mem_req, 1'b1);
    check32("first_fetch_addr", mem_addr, 32'h0000_3000);
    check32("nh_first_fetch", mem_addr2, 32'h0000_3000);
    @(negedge clk);
    check1("nh_illegal_retire", retire2, 1'b1);
    check32("nh_illegal_pc", retire_pc2, 32'h0000_3000);
    check1("nh_not_halted", halted2, 1'b0);
    @(negedge clk);
    check1("nh_next_req", mem_req2, 1'b1);
    check32("nh_next_fetch", mem_addr2, 32'h0000_3004);

    for (int i = 0; i < 18; i++) begin
      wait_retire($sformatf("vec%0d_pc", i), 32'h3000 + 32'(4 * i), cyc);
      if (vecs[i].st) check_store($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_data);
      else            check1($sformatf("vec%0d_we", i), r_we, 1'b0);
    end

    // ---- sw/lw with three wait states on data accesses ----
    hold_reset();
    clear_imem();
    put(32'h3000, 32'h3401_1234);  // ori $1,$0,0x1234
    put(32'h3004, 32'hAC01_0008);  // sw  $1,8($0)
    put(32'h3008, 32'h8C05_0008);  // lw  $5,8($0)
    put(32'h300C, 32'hAC05_000C);  // sw  $5,12($0)
    data_wait = 3;
    reset = 1'b0;
    wait_retire("ws_ori", 32'h3000, cyc);
    wait_retire("ws_sw", 32'h3004, cyc);
    check32("ws_sw_latency", 32'(cyc), 32'd7);
    check_store("ws_sw", 32'h8, 32'h0000_1234);
    wait_retire("ws_lw", 32'h3008, cyc);
    check32("ws_lw_latency", 32'(cyc), 32'd8);
    wait_retire("ws_sw2", 32'h300C, cyc);
    check_store("ws_sw2", 32'hC, 32'h0000_1234);

    // ---- branches, jal/jr, illegal halt ----
    hold_reset();
    clear_imem();
    data_wait = 0;
    put(32'h3000, 32'h3401_1234);  // ori $1,$0,0x1234
    put(32'h3004, 32'h3C02_ABCD);  // lui $2,0xABCD
    put(32'h3010, 32'h1021_FFFF);  // beq $1,$1,-1
    put(32'h3020, 32'h0C00_0C01);  // jal 0x0C01
    put(32'h3024, 32'hAC1F_0020);  // sw  $31,0x20($0)
    put(32'h3028, 32'h1000_0002);  // beq $0,$0,+2
    put(32'h3034, 32'hFC00_0000);  // illegal
    reset = 1'b0;
    wait_retire("br_ori", 32'h3000, cyc);
    wait_retire("br_lui", 32'h3004, cyc);
    wait_retire("br_nop0", 32'h3008, cyc);
    wait_retire("br_nop1", 32'h300C, cyc);
    wait_retire("beq_taken", 32'h3010, cyc);
    check_fetch("beq_taken_tgt", 32'h3010);
    put(32'h3010, 32'h1022_0004);  // becomes beq $1,$2,+4 (not taken)
    wait_retire("beq_nt", 32'h3010, cyc);
    check_fetch("beq_nt_tgt", 32'h3014);
    wait_retire("br_nop2", 32'h3014, cyc);
    wait_retire("br_nop3", 32'h3018, cyc);
    wait_retire("br_nop4", 32'h301C, cyc);
    wait_retire("jal", 32'h3020, cyc);
    check_fetch("jal_tgt", 32'h3004);
    put(32'h3004, 32'h03E0_0008);  // becomes jr $31
    wait_retire("jr", 32'h3004, cyc);
    check_fetch("jr_tgt", 32'h3024);
    wait_retire("sw_ra", 32'h3024, cyc);
    check_store("sw_ra", 32'h20, 32'h0000_3024);
    wait_retire("beq_fwd", 32'h3028, cyc);
    check_fetch("beq_fwd_tgt", 32'h3034);
    repeat (5) @(negedge clk);
    check1("halt_halted", halted, 1'b1);
    check1("halt_req", mem_req, 1'b0);
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req || retire || !halted) quiet++;
    end
    check32("halt_stays_quiet", 32'(quiet), 32'd0);

    // ---- reset while a sw waits in MEM ----
    hold_reset();
    check1("rst_from_halt", halted, 1'b0);
    clear_imem();
    put(32'h3000, 32'h3401_1234);  // ori $1,$0,0x1234
    put(32'h3004, 32'h3C02_ABCD);  // lui $2,0xABCD
    put(32'h3008, 32'h0C00_0C04);  // jal 0x0C04 -> $31=0x300C
    put(32'h3010, 32'hAC01_0008);  // sw $1,8($0)
    data_wait = 3;
    reset = 1'b0;
    wait_retire("mr_ori", 32'h3000, cyc);
    wait_retire("mr_lui", 32'h3004, cyc);
    wait_retire("mr_jal", 32'h3008, cyc);
    cyc = 0;
    while (!(mem_req && mem_we) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check1("mr_store_pending", mem_req && mem_we, 1'b1);
    saved_writes = n_writes;
    reset = 1'b1;
    #1;
    check1("mr_req_drop", mem_req, 1'b0);
    check1("mr_we_drop", mem_we, 1'b0);
    check1("mr_no_retire", retire, 1'b0);
    repeat (3) @(negedge clk);
    clear_imem();
    for (int i = 0; i < 32; i++) begin
      put(32'h3000 + 32'(4 * i),
          32'hAC00_0000 | (32'(i) << 16) | (32'h400 + 32'(4 * i)));
      exp_q.push_back(32'h0);
    end
    data_wait = 0;
    reset = 1'b0;
    #1;
    check32("mr_refetch", mem_addr, 32'h0000_3000);
    check32("mr_no_write", 32'(n_writes), 32'(saved_writes));
    for (int i = 0; i < 32; i++) begin
      wait_retire($sformatf("grf%0d_pc", i), 32'h3000 + 32'(4 * i), cyc);
      check32($sformatf("grf%0d_addr", i), r_addr, 32'h400 + 32'(4 * i));
      check32($sformatf("grf%0d_zero", i), r_wdata, exp_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
